m_axi4_fsb_reader: RTL and testbench

M_AXI4_FSB_READER -- requirements
Module: m_axi4_fsb_reader

---
 rtl/m_axi4_fsb_reader.sv | 201 ++++++++++++++++++++
 tb/tb_m_axi4_fsb_reader.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_axi4_fsb_reader.sv
// AXI4 read master: bursts 512-bit beats into a FIFO and unpacks FSB lanes.
// Optional macro FSB_READER_RRESP_CHECK_EN: flag and discard error responses.
module m_axi4_fsb_reader #(
    parameter int DATA_WIDTH = 512,
    parameter int FSB_WIDTH  = 80,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_BEATS = 16
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  start_i,
    input  logic [63:0]           base_addr_i,
    input  logic [15:0]           num_beats_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [5:0]            arid_o,
    output logic [63:0]           araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [5:0]            rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  fsb_v_o,
    output logic [FSB_WIDTH-1:0]  fsb_data_o,
    input  logic                  fsb_yumi_i
);
    localparam int LANE_W = 4 * FSB_WIDTH;
    localparam int ENT_W  = LANE_W + 4;
    localparam int PTR_W  = $clog2(FIFO_BEATS);
    localparam int CNT_W  = $clog2(FIFO_BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

    state_t           r_state;
    logic [63:0]      r_base, r_araddr;
    logic [15:0]      r_rem, r_issued;
    logic [7:0]       r_arlen;
    logic             r_arvalid, r_done, r_err, r_discard;
    logic [ENT_W-1:0] r_mem [FIFO_BEATS];
    logic [PTR_W-1:0] r_wp, r_rp;
    logic [CNT_W-1:0] r_cnt;
    logic [LANE_W-1:0] r_ub;
    logic [3:0]       r_um;
    logic             r_fv;
    logic [FSB_WIDTH-1:0] r_fd;

    logic             w_rhs, w_bad, w_push, w_pop, w_take, w_space, w_empty;
    logic [15:0]      w_blen, w_alen;
    logic [ENT_W-1:0] w_pk, w_head;
    logic [1:0]       w_lane;
    logic [3:0]       w_um_nxt;
    logic [FSB_WIDTH-1:0] w_lane_d;
    logic             w_unused;

    assign w_unused = ^{rid_i, rdata_i, rresp_i};

`ifdef FSB_READER_RRESP_CHECK_EN
    assign w_bad = rresp_i != 2'b00;
`else
    assign w_bad = 1'b0;
`endif

    assign w_rhs   = rvalid_i && rready_o;
    assign w_push  = w_rhs && !r_discard && !w_bad;
    assign w_space = (CNT_W'(FIFO_BEATS) - r_cnt) >= CNT_W'(BURST_LEN);
    assign w_blen  = (r_rem < 16'(BURST_LEN)) ? r_rem : 16'(BURST_LEN);
    assign w_alen  = {8'd0, r_arlen} + 16'd1;
    assign w_empty = (r_cnt == '0) && (r_um == 4'd0) && !r_fv;
    assign w_head  = r_mem[r_rp];

    // Each beat is stored compacted: 4 packets plus their lane-valid flags.
    always_comb begin
        w_pk = '0;
        for (int k = 0; k < 4; k++) begin
            w_pk[k*FSB_WIDTH +: FSB_WIDTH] = rdata_i[k*128 +: FSB_WIDTH];
            w_pk[LANE_W+k] = rdata_i[k*128+127];
        end
    end

    always_comb begin
        w_lane = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (r_um[k]) w_lane = 2'(k);
        end
    end

    assign w_take   = (r_um != 4'd0) && (!r_fv || fsb_yumi_i);
    assign w_um_nxt = w_take ? (r_um & ~(4'd1 << w_lane)) : r_um;
    assign w_lane_d = r_ub[int'(w_lane)*FSB_WIDTH +: FSB_WIDTH];
    // Refill the unpacker in the cycle its last lane leaves, so lanes stream back to back.
    assign w_pop    = (w_um_nxt == 4'd0) && (r_cnt != '0);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_araddr  <= '0;
            r_rem     <= '0;
            r_issued  <= '0;
            r_arlen   <= '0;
            r_arvalid <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: if (start_i) begin
                    r_base    <= base_addr_i;
                    r_rem     <= num_beats_i;
                    r_issued  <= '0;
                    r_err     <= 1'b0;
                    r_discard <= 1'b0;
                    if (num_beats_i != 16'd0) r_state <= S_ADDR;
                    else r_done <= 1'b1;
                end
                S_ADDR: begin
                    if (!r_arvalid) begin
                        if (w_space) begin
                            r_arvalid <= 1'b1;
                            r_araddr  <= r_base + {42'd0, r_issued, 6'd0};
                            r_arlen   <= 8'(w_blen - 16'd1);
                        end
                    end else if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rem     <= r_rem - w_alen;
                        r_issued  <= r_issued + w_alen;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_rhs && w_bad) begin
                        r_err     <= 1'b1;
                        r_discard <= 1'b1;
                    end
                    if (w_rhs && rlast_i)
                        r_state <= (r_rem != 16'd0 && !r_discard && !w_bad)
                                   ? S_ADDR : S_DRAIN;
                end
                S_DRAIN: if (w_empty) begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= w_pk;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ub  <= '0;
            r_um  <= '0;
            r_fv  <= 1'b0;
            r_fd  <= '0;
        end else begin
            if (w_push)
                r_wp <= (r_wp == PTR_W'(FIFO_BEATS-1)) ? '0 : r_wp + 1'b1;
            if (w_pop)
                r_rp <= (r_rp == PTR_W'(FIFO_BEATS-1)) ? '0 : r_rp + 1'b1;
            if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            if (w_pop) begin
                r_ub <= w_head[LANE_W-1:0];
                r_um <= w_head[ENT_W-1:LANE_W];
            end else begin
                r_um <= w_um_nxt;
            end
            if (w_take) begin
                r_fv <= 1'b1;
                r_fd <= w_lane_d;
            end else if (fsb_yumi_i) begin
                r_fv <= 1'b0;
            end
        end
    end

    assign busy_o     = r_state != S_IDLE;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign arid_o     = 6'h0;
    assign araddr_o   = r_araddr;
    assign arlen_o    = r_arlen;
    assign arsize_o   = (r_state == S_ADDR) ? 3'h6 : 3'h0;
    assign arvalid_o  = r_arvalid;
    assign rready_o   = (r_state == S_DATA) && (r_cnt != CNT_W'(FIFO_BEATS));
    assign fsb_v_o    = r_fv;
    assign fsb_data_o = r_fd;
endmodule

// File: tb/tb_m_axi4_fsb_reader.sv
// Randomised bench for m_axi4_fsb_reader with an AXI slave and packet model.
// Define FSB_READER_RRESP_CHECK_EN to exercise the error-response path.
module tb_m_axi4_fsb_reader;
    localparam int FW = 80;

    logic clk_i = 1'b0, resetn_i = 1'b0, start_i = 1'b0;
    logic [63:0] base_addr_i = '0;
    logic [15:0] num_beats_i = '0;
    logic busy_o, done_o, err_o, arvalid_o, rready_o, fsb_v_o;
    logic [5:0] arid_o;
    logic [63:0] araddr_o;
    logic [7:0] arlen_o;
    logic [2:0] arsize_o;
    logic [FW-1:0] fsb_data_o;
    logic arready_i = 1'b0, rlast_i = 1'b0, rvalid_i = 1'b0, fsb_yumi_i = 1'b0;
    logic [5:0] rid_i = '0;
    logic [511:0] rdata_i = '0;
    logic [1:0] rresp_i = '0;

    m_axi4_fsb_reader dut (
        .clk_i(clk_i), .resetn_i(resetn_i), .start_i(start_i),
        .base_addr_i(base_addr_i), .num_beats_i(num_beats_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
        .arsize_o(arsize_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .fsb_v_o(fsb_v_o), .fsb_data_o(fsb_data_o), .fsb_yumi_i(fsb_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [511:0] beats [64];
    int err_beat = -1;
    int yumi_mode = 2;
    logic [63:0] base_cur = '0;
    logic [FW-1:0] got_q [$], exp_q [$];
    int got_cyc [$];
    logic [63:0] ar_a [$], ea [$];
    logic [7:0] ar_l [$], el [$];
    int b_start [$], b_len [$];
    int cur = 0, left = 0;
    bit r_active = 0, ar_pend = 0;
    logic [63:0] ar_pa = '0;
    logic [7:0] ar_pl = '0;
    int rbeats = 0, hs_cyc = -1, first_v_cyc = -1;
    int done_cnt = 0, arv_seen = 0, err_seen = 0, ar_unstable = 0, ar_bad = 0;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    // AXI slave and FSB consumer; inputs change on the falling edge.
    initial forever begin
        @(negedge clk_i);
        if (!resetn_i) begin
            b_start.delete(); b_len.delete();
            r_active = 0; ar_pend = 0;
            arready_i = 0; rvalid_i = 0; rlast_i = 0; rresp_i = 0; fsb_yumi_i = 0;
        end else begin
            if (!r_active && b_start.size() > 0) begin
                cur = b_start.pop_front();
                left = b_len.pop_front();
                r_active = 1;
            end
            if (r_active) begin
                rvalid_i = ($urandom_range(0, 3) != 0);
                rdata_i = beats[cur];
                rlast_i = (left == 1);
                rresp_i = (cur == err_beat) ? 2'b10 : 2'b00;
            end else begin
                rvalid_i = 0; rlast_i = 0; rresp_i = 0;
            end
            if (rvalid_i && rready_o) begin
                if (hs_cyc < 0) hs_cyc = cyc;
                rbeats++; cur++; left--;
                if (left == 0) r_active = 0;
            end
            if (ar_pend && (arvalid_o !== 1'b1 || araddr_o !== ar_pa || arlen_o !== ar_pl))
                ar_unstable++;
            arready_i = ($urandom_range(0, 2) != 0);
            if (arvalid_o && arready_i) begin
                ar_a.push_back(araddr_o);
                ar_l.push_back(arlen_o);
                if (arsize_o !== 3'h6 || arid_o !== 6'h0) ar_bad++;
                b_start.push_back(int'((araddr_o - base_cur) >> 6));
                b_len.push_back(int'(arlen_o) + 1);
                ar_pend = 0;
            end else begin
                ar_pend = arvalid_o;
                ar_pa = araddr_o;
                ar_pl = arlen_o;
            end
            if (fsb_v_o && first_v_cyc < 0) first_v_cyc = cyc;
            fsb_yumi_i = fsb_v_o && (yumi_mode == 1 ||
                         (yumi_mode == 2 && $urandom_range(0, 1) == 1));
            if (fsb_yumi_i) begin
                got_q.push_back(fsb_data_o);
                got_cyc.push_back(cyc);
            end
            if (done_o) done_cnt++;
            if (arvalid_o) arv_seen++;
            if (err_o) err_seen++;
        end
    end

    task automatic gen_beats(input int n, input int pct);
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < 16; w++) beats[b][32*w +: 32] = $urandom;
            for (int k = 0; k < 4; k++) beats[b][128*k+127] = ($urandom_range(0, 99) < pct);
        end
    endtask

    // Reference: ARs cover n_ar beats in BURST_LEN chunks; packets from the first n_pk beats.
    function automatic void model(input int n_ar, input int n_pk);
        exp_q.delete(); ea.delete(); el.delete();
        for (int b = 0; b < n_pk; b++)
            for (int k = 0; k < 4; k++)
                if (beats[b][128*k+127]) exp_q.push_back(beats[b][128*k +: FW]);
        for (int s = 0; s < n_ar; s += 8) begin
            ea.push_back(base_cur + 64'(s) * 64);
            el.push_back(8'(((n_ar - s) < 8 ? (n_ar - s) : 8) - 1));
        end
    endfunction

    function automatic int pk_diff();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    function automatic int ar_diff();
        for (int i = 0; i < ar_a.size() && i < ea.size(); i++)
            if (ar_a[i] !== ea[i] || ar_l[i] !== el[i]) return i;
        return -1;
    endfunction

    task automatic kick(input logic [63:0] b, input int n);
        @(negedge clk_i);
        got_q.delete(); got_cyc.delete(); ar_a.delete(); ar_l.delete();
        rbeats = 0; hs_cyc = -1; first_v_cyc = -1;
        base_cur = b; base_addr_i = b; num_beats_i = 16'(n); start_i = 1;
        @(negedge clk_i);
        start_i = 0;
    endtask

    task automatic wait_done(input int d0, output bit to);
        to = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_i);
            if (done_cnt > d0) begin
                to = 0;
                break;
            end
        end
        repeat (4) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, err_o, arvalid_o, rready_o, fsb_v_o, araddr_o, arlen_o,
             arsize_o, arid_o, fsb_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs busy %b arvalid %b fsb_v %b data %h required all 0",
                     busy_o, arvalid_o, fsb_v_o, fsb_data_o);
        end
        resetn_i = 1;
        @(negedge clk_i);
        checks++;
        if ({busy_o, done_o, arvalid_o, rready_o, fsb_v_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_release busy %b done %b arvalid %b required 0", busy_o, done_o, arvalid_o);
        end
    endtask

    task automatic test_zero_beats();
        int d0 = done_cnt, a0 = arv_seen;
        kick(64'h2000, 0);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL zero_done got %b required 1", done_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_after done %b busy %b required 0 0", done_o, busy_o);
        end
        repeat (6) @(negedge clk_i);
        checks++;
        if (arv_seen != a0 || done_cnt != d0 + 1) begin
            errors++;
            $display("FAIL zero_ar arvalid cycles %0d dones %0d required 0 1", arv_seen - a0, done_cnt - d0);
        end
    endtask

    task automatic test_main();
        bit to;
        int d0 = done_cnt, i;
        gen_beats(20, 100);
        yumi_mode = 2;
        ar_unstable = 0; ar_bad = 0;
        kick(64'h1000, 20);
        model(20, 20);
        wait_done(d0, to);
        checks++;
        if (to) begin errors++; $display("FAIL main_timeout got no done required done"); end
        checks++;
        if (ar_a.size() != 3 || ea.size() != 3) begin
            errors++;
            $display("FAIL main_ar_count got %0d required 3", ar_a.size());
        end
        i = ar_diff();
        checks++;
        if (i >= 0) begin
            errors++;
            $display("FAIL main_ar idx %0d got %h/%0d required %h/%0d", i, ar_a[i], ar_l[i], ea[i], el[i]);
        end
        checks++;
        if (got_q.size() != 80) begin errors++; $display("FAIL main_count got %0d required 80", got_q.size()); end
        i = pk_diff();
        checks++;
        if (i >= 0) begin errors++; $display("FAIL main_pkt idx %0d got %h required %h", i, got_q[i], exp_q[i]); end
        checks++;
        if (done_cnt != d0 + 1) begin errors++; $display("FAIL main_done got %0d required 1", done_cnt - d0); end
        checks++;
        if (ar_unstable != 0 || ar_bad != 0) begin
            errors++;
            $display("FAIL main_ar_fields unstable %0d bad %0d required 0 0", ar_unstable, ar_bad);
        end
        checks++;
        if (busy_o !== 1'b0 || fsb_v_o !== 1'b0) begin
            errors++;
            $display("FAIL main_idle busy %b fsb_v %b required 0 0", busy_o, fsb_v_o);
        end
    endtask

    task automatic test_sparse();
        bit to;
        int d0 = done_cnt;
        gen_beats(1, 100);
        beats[0][127] = 1'b1; beats[0][255] = 1'b0;
        beats[0][383] = 1'b1; beats[0][511] = 1'b0;
        yumi_mode = 1;
        kick(64'h20000, 1);
        model(1, 1);
        wait_done(d0, to);
        checks++;
        if (to || got_q.size() != 2) begin
            errors++;
            $display("FAIL sparse_count got %0d timeout %0d required 2", got_q.size(), to);
        end else begin
            checks++;
            if (got_q[0] !== beats[0][FW-1:0] || got_q[1] !== beats[0][256 +: FW]) begin
                errors++;
                $display("FAIL sparse_data got %h %h required %h %h", got_q[0], got_q[1], exp_q[0], exp_q[1]);
            end
            checks++;
            if (got_cyc[1] - got_cyc[0] != 1) begin
                errors++;
                $display("FAIL sparse_gap got %0d required 1", got_cyc[1] - got_cyc[0]);
            end
            checks++;
            if (first_v_cyc - (hs_cyc + 1) != 2) begin
                errors++;
                $display("FAIL latency got %0d required 2", first_v_cyc - (hs_cyc + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        int d0 = done_cnt, i;
        gen_beats(40, 100);
        yumi_mode = 0;
        kick(64'h10000, 40);
        model(40, 40);
        repeat (100) @(negedge clk_i);
        checks++;
        if (rready_o !== 1'b0 || arvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall rready %b arvalid %b required 0 0", rready_o, arvalid_o);
        end
        checks++;
        if (rbeats < 16 || rbeats > 17 || got_q.size() != 0) begin
            errors++;
            $display("FAIL bp_held beats %0d packets %0d required 16..17 and 0", rbeats, got_q.size());
        end
        yumi_mode = 2;
        wait_done(d0, to);
        checks++;
        if (to || got_q.size() != 160) begin
            errors++;
            $display("FAIL bp_count got %0d timeout %0d required 160", got_q.size(), to);
        end
        i = pk_diff();
        checks++;
        if (i >= 0) begin errors++; $display("FAIL bp_pkt idx %0d got %h required %h", i, got_q[i], exp_q[i]); end
    endtask

    task automatic test_rresp();
        bit to;
        int d0 = done_cnt, e0 = err_seen, i;
        gen_beats(20, 100);
        yumi_mode = 2;
        err_beat = 3;
`ifdef FSB_READER_RRESP_CHECK_EN
        kick(64'h8000, 20);
        model(8, 3);
        wait_done(d0, to);
        err_beat = -1;
        checks++;
        if (to || err_o !== 1'b1) begin
            errors++;
            $display("FAIL rresp_err got %b timeout %0d required 1", err_o, to);
        end
        checks++;
        if (got_q.size() != 12 || ar_a.size() != 1) begin
            errors++;
            $display("FAIL rresp_count packets %0d bursts %0d required 12 1", got_q.size(), ar_a.size());
        end
        i = pk_diff();
        checks++;
        if (i >= 0) begin errors++; $display("FAIL rresp_pkt idx %0d got %h required %h", i, got_q[i], exp_q[i]); end
        kick(64'h0, 0);
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL rresp_clear got %b required 0", err_o); end
`else
        kick(64'h8000, 8);
        model(8, 8);
        wait_done(d0, to);
        err_beat = -1;
        checks++;
        if (to || err_seen != e0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL rresp_ignored err cycles %0d timeout %0d required 0", err_seen - e0, to);
        end
        i = pk_diff();
        checks++;
        if (i >= 0 || got_q.size() != 32) begin
            errors++;
            $display("FAIL rresp_pkts count %0d diff %0d required 32 -1", got_q.size(), i);
        end
`endif
    endtask

    task automatic test_random();
        bit to;
        int d0, n, i;
        logic [63:0] b;
        for (int it = 0; it < 4; it++) begin
            d0 = done_cnt;
            b = {$urandom, $urandom} & ~64'h1FF;
            n = $urandom_range(1, 48);
            gen_beats(n, $urandom_range(0, 100));
            yumi_mode = 2;
            kick(b, n);
            model(n, n);
            wait_done(d0, to);
            checks++;
            if (to || ar_a.size() != ea.size() || ar_diff() >= 0) begin
                errors++;
                $display("FAIL rand_ar iter %0d bursts %0d required %0d timeout %0d", it, ar_a.size(), ea.size(), to);
            end
            i = pk_diff();
            checks++;
            if (i >= 0 || got_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_pkt iter %0d count %0d required %0d diff %0d", it, got_q.size(), exp_q.size(), i);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int d0, i;
        gen_beats(20, 100);
        yumi_mode = 2;
        kick(64'h4000, 20);
        for (int k = 0; k < 2000 && rbeats < 3; k++) @(negedge clk_i);
        checks++;
        if (rbeats < 3) begin errors++; $display("FAIL mid_wait beats %0d required 3", rbeats); end
        #2 resetn_i = 0;
        #1;
        checks++;
        if ({busy_o, done_o, err_o, arvalid_o, rready_o, fsb_v_o, araddr_o, arlen_o,
             arsize_o, fsb_data_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset busy %b rready %b fsb_v %b araddr %h required all 0",
                     busy_o, rready_o, fsb_v_o, araddr_o);
        end
        repeat (2) @(negedge clk_i);
        d0 = done_cnt;
        got_q.delete(); got_cyc.delete(); ar_a.delete(); ar_l.delete();
        rbeats = 0; hs_cyc = -1; first_v_cyc = -1;
        base_cur = 64'h6000; base_addr_i = 64'h6000; num_beats_i = 16'd20;
        resetn_i = 1; start_i = 1;
        @(negedge clk_i);
        start_i = 0;
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_first_start got %b required 1", busy_o); end
        model(20, 20);
        wait_done(d0, to);
        i = pk_diff();
        checks++;
        if (to || i >= 0 || got_q.size() != 80 || ar_diff() >= 0 || ar_a.size() != 3) begin
            errors++;
            $display("FAIL mid_restart packets %0d bursts %0d diff %0d required 80 3 -1", got_q.size(), ar_a.size(), i);
        end
    endtask

    initial begin
        test_reset();
        test_zero_beats();
        test_main();
        test_sparse();
        test_backpressure();
        test_rresp();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
